shifter_iter: RTL and testbench

SHIFTER_ITER -- requirements
Module: shifter_iter

---
 rtl/shifter_iter.sv | 82 ++++++++
 tb/tb_shifter_iter.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/shifter_iter.sv
// shifter_iter: iterative shifter that moves up to three bit positions per cycle
module shifter_iter #(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [WIDTH-1:0]   din,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   dout
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state, state_nxt;
    logic [1:0]         op_q;
    logic [SHAMT_W-1:0] rem;
    logic [1:0]         step;
    logic [WIDTH-1:0]   cand [4];
    logic [WIDTH-1:0]   shifted;
    logic               accept;

    assign accept  = start && state != BUSY;
    assign step    = (rem > SHAMT_W'(3)) ? 2'd3 : rem[1:0];
    assign busy    = state == BUSY;
    assign done    = state == DONE;

    // Candidate results for distances 0..3; ASR keeps replicating the MSB,
    // which never changes during an ASR sequence, so it is the original sign.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            case (op_q)
                2'b00:   cand[k] = dout << k;
                2'b01:   cand[k] = dout >> k;
                2'b10:   cand[k] = $signed(dout) >>> k;
                default: cand[k] = (dout >> k) | (dout << (WIDTH - k));
            endcase
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign shifted[i] = cand[step][i];
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next state: finish in the cycle the remaining distance is consumed
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = start ? BUSY : IDLE;
            BUSY:    state_nxt = (rem == SHAMT_W'(step)) ? DONE : BUSY;
            DONE:    state_nxt = start ? BUSY : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: load on an accepted start, step the shift while busy, hold otherwise
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q <= 2'b00;
            rem  <= '0;
            dout <= '0;
        end else if (accept) begin
            op_q <= op;
            rem  <= shamt;
            dout <= din;
        end else if (state == BUSY) begin
            rem  <= rem - SHAMT_W'(step);
            dout <= shifted;
        end
    end

endmodule

// File: tb/tb_shifter_iter.sv
// tb_shifter_iter: table-driven scoreboard bench for shifter_iter (WIDTH=8)
module tb_shifter_iter;

    logic       clk, reset_n, start, busy, done;
    logic [1:0] op;
    logic [2:0] shamt;
    logic [7:0] din, dout;

    typedef struct {
        logic [1:0] op;
        logic [2:0] shamt;
        logic [7:0] din;
        logic [7:0] exp;
    } vec_t;

    typedef struct {
        logic [7:0] dout;
        int         cyc;
    } exp_t;

    exp_t       sb [$];
    int         total, passed, bcnt;
    logic [7:0] last_exp;

    shifter_iter #(.WIDTH(8)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .op(op), .shamt(shamt),
        .din(din), .busy(busy), .done(done), .dout(dout)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic logic [7:0] ref_shift(input logic [1:0] o, input logic [2:0] s, input logic [7:0] d);
        logic signed [7:0] sd;
        sd = d;
        case (o)
            2'b00:   ref_shift = d << s;
            2'b01:   ref_shift = d >> s;
            2'b10:   ref_shift = sd >>> s;
            default: ref_shift = (d >> s) | (d << (8 - s));
        endcase
    endfunction

    function automatic int cyc_of(input logic [2:0] s);
        return (s == 0) ? 1 : (int'(s) + 2) / 3;
    endfunction

    // Monitor: count busy cycles, and on each done compare against the oldest expectation
    always @(negedge clk) begin
        if (!reset_n) bcnt = 0;
        else if (busy) bcnt++;
        else if (done) begin
            if (sb.size() == 0) chk("unexpected_done", 1, 0);
            else begin
                exp_t e;
                e = sb.pop_front();
                chk("result", dout, e.dout);
                chk("busy_cycles", bcnt, e.cyc);
                last_exp = e.dout;
            end
            bcnt = 0;
        end
    end

    // Drive a start for one edge and record what the result must be
    task automatic issue(input logic [1:0] o, input logic [2:0] s, input logic [7:0] d, input logic [7:0] e);
        exp_t x;
        start = 1; op = o; shamt = s; din = d;
        x.dout = e; x.cyc = cyc_of(s);
        sb.push_back(x);
        @(negedge clk);
        start = 0;
    endtask

    // Wait for the scoreboard to drain, then confirm idle with the result held
    task automatic finish_op(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_timeout"}, sb.size(), 0);
        @(negedge clk);
        chk({name, "_done_low"}, done, 0);
        chk({name, "_busy_low"}, busy, 0);
        chk({name, "_hold"}, dout, last_exp);
    endtask

    vec_t vecs [$];

    initial begin
        total = 0; passed = 0; bcnt = 0; last_exp = 0;
        start = 0; op = 0; shamt = 0; din = 0;
        vecs.push_back('{2'b00, 3'd7, 8'h01, 8'h80});
        vecs.push_back('{2'b10, 3'd3, 8'h80, 8'hF0});
        vecs.push_back('{2'b10, 3'd7, 8'h80, 8'hFF});
        vecs.push_back('{2'b11, 3'd1, 8'h81, 8'hC0});
        vecs.push_back('{2'b01, 3'd0, 8'hA5, 8'hA5});
        vecs.push_back('{2'b01, 3'd4, 8'hF0, 8'h0F});
        vecs.push_back('{2'b11, 3'd4, 8'h12, 8'h21});
        vecs.push_back('{2'b00, 3'd5, 8'hFF, 8'hE0});
        vecs.push_back('{2'b10, 3'd6, 8'h7F, 8'h01});
        vecs.push_back('{2'b11, 3'd7, 8'h01, 8'h02});
        vecs.push_back('{2'b10, 3'd2, 8'hC4, 8'hF1});
        for (int i = 0; i < 10; i++) begin
            vec_t v;
            v.op = 2'($urandom_range(0, 3));
            v.shamt = 3'($urandom_range(0, 7));
            v.din = 8'($urandom);
            v.exp = ref_shift(v.op, v.shamt, v.din);
            vecs.push_back(v);
        end

        reset_n = 0;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_dout", dout, 0);

        // Start presented together with reset release is taken on the first edge
        @(negedge clk);
        reset_n = 1;
        foreach (vecs[i]) begin
            issue(vecs[i].op, vecs[i].shamt, vecs[i].din, vecs[i].exp);
            finish_op($sformatf("vec%0d", i));
        end

        // Start during BUSY is ignored
        issue(2'b00, 3'd7, 8'h01, 8'h80);
        start = 1; op = 2'b11; shamt = 3'd1; din = 8'hFF;
        @(negedge clk);
        start = 0;
        finish_op("ignore_busy_start");

        // Start on the done cycle: busy on the very next cycle
        issue(2'b10, 3'd4, 8'h90, 8'hF9);
        for (int n = 0; n < 10 && !done; n++) @(negedge clk);
        chk("b2b_done_seen", done, 1);
        issue(2'b11, 3'd3, 8'h0F, 8'hE1);
        chk("b2b_busy_next", busy, 1);
        finish_op("b2b");

        // Reset in the second BUSY cycle aborts with no done
        issue(2'b00, 3'd7, 8'h01, 8'h80);
        @(negedge clk);
        chk("abort_in_busy", busy, 1);
        reset_n = 0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_dout", dout, 0);
        chk("abort_done", done, 0);
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        chk("abort_no_done", done, 0);
        reset_n = 1;
        issue(2'b01, 3'd5, 8'hC0, 8'h06);
        finish_op("after_abort");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
